// File: rtl/mac_array_if.sv
// rtl/mac_array_if.sv - operand/result handshake bundle for mac_array
interface mac_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH
) ();
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DATA_WIDTH-1:0] a_in;
  logic [LANES*DATA_WIDTH-1:0] b_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*ACC_WIDTH-1:0]  acc_out;
  logic [LANES-1:0]            ovf;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, acc_out, ovf
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, acc_out, ovf
  );
endinterface

// File: rtl/mac_array.sv
// rtl/mac_array.sv - LANES-wide pipelined multiply-accumulate dot-product engine
// Optional MAC_SATURATE_EN: clamp accumulators on overflow instead of wrapping.
module mac_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int ACC_WIDTH  = 3*DATA_WIDTH,
  parameter int VEC_LEN    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  mac_array_if.slave  bus
);
  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PW    = 2*DATA_WIDTH;

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     count, count_n;
  logic                 accept;
  logic                 consume;
  logic                 last_beat;
  logic                 prod_vld;
  logic [PW-1:0]        prod   [LANES];
  logic [PW-1:0]        prod_n [LANES];
  logic [ACC_WIDTH-1:0] acc    [LANES];
  logic [ACC_WIDTH:0]   sum    [LANES];
  logic [LANES-1:0]     ovf_r;

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == DONE);
  assign bus.ovf       = ovf_r;

  assign accept    = bus.in_valid && (state == ACCUM);
  assign consume   = bus.out_ready && (state == DONE);
  assign last_beat = (count == CNT_W'(VEC_LEN-1));

  // The extra sum bit is the carry out of the accumulator, i.e. the overflow.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign prod_n[g] = PW'(bus.a_in[g*DATA_WIDTH +: DATA_WIDTH])
                     * PW'(bus.b_in[g*DATA_WIDTH +: DATA_WIDTH]);
    assign sum[g]    = {1'b0, acc[g]} + (ACC_WIDTH+1)'(prod[g]);
    assign bus.acc_out[g*ACC_WIDTH +: ACC_WIDTH] = acc[g];
  end

  always_comb begin
    state_n = state;
    count_n = count;
    case (state)
      ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            state_n = DRAIN;
            count_n = '0;
          end else begin
            count_n = count + CNT_W'(1);
          end
        end
      end
      DRAIN:   state_n = DONE;
      DONE:    if (bus.out_ready) state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      count <= '0;
    end else if (clr) begin
      state <= ACCUM;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end

  // DRAIN exists so the last product lands in acc before out_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_vld <= 1'b0;
      ovf_r    <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else if (clr) begin
      prod_vld <= 1'b0;
      ovf_r    <= '0;
      for (int i = 0; i < LANES; i++) begin
        prod[i] <= '0;
        acc[i]  <= '0;
      end
    end else begin
      prod_vld <= accept;
      for (int i = 0; i < LANES; i++) begin
        if (accept) prod[i] <= prod_n[i];
        if (consume) begin
          acc[i]   <= '0;
          ovf_r[i] <= 1'b0;
        end else if (prod_vld) begin
          ovf_r[i] <= ovf_r[i] | sum[i][ACC_WIDTH];
`ifdef MAC_SATURATE_EN
          if (sum[i][ACC_WIDTH] || ovf_r[i]) acc[i] <= '1;
          else                               acc[i] <= sum[i][ACC_WIDTH-1:0];
`else
          acc[i] <= sum[i][ACC_WIDTH-1:0];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_array.sv
// tb/tb_mac_array.sv - directed self-checking bench for mac_array
module tb_mac_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clr2 = 1'b0;
  int checks = 0;
  int failures = 0;

  localparam logic [95:0] EXP_MAIN = {24'd260100, 24'd80000, 24'd30, 24'd20};
  localparam logic [95:0] EXP_ONES = {24'd4, 24'd4, 24'd4, 24'd4};
`ifdef MAC_SATURATE_EN
  localparam logic [31:0] EXP_OVF = {16'd2, 16'd65535};
`else
  localparam logic [31:0] EXP_OVF = {16'd2, 16'd64514};
`endif

  mac_array_if #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24)) bus ();
  mac_array_if #(.DATA_WIDTH(8), .LANES(2), .ACC_WIDTH(16)) bus2 ();

  mac_array #(.DATA_WIDTH(8), .LANES(4), .ACC_WIDTH(24), .VEC_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus)
  );
  mac_array #(.DATA_WIDTH(8), .LANES(2), .ACC_WIDTH(16), .VEC_LEN(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .bus(bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_beat(input int k);
    bus.a_in = {8'd255, 8'd200, 8'(k), 8'(k)};
    bus.b_in = {8'd255, 8'd100, 8'(k), 8'd2};
  endtask

  // Ends at the negedge right after the edge accepting the last beat.
  task automatic send_vector(input bit gap);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_beat(k);
      if (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.acc_out !== 96'd0 || bus.ovf !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state acc=%0h ovf=%0b ov=%0b ir=%0b expected acc=0 ovf=0 ov=0 ir=1",
               bus.acc_out, bus.ovf, bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_beat(k);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.acc_out[23:0] !== 24'd6) begin
      failures++;
      $display("FAIL pre_reset_lane0 got=%0d expected=6", bus.acc_out[23:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.acc_out !== 96'd0 || bus.ovf !== 4'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset acc=%0h ovf=%0b ov=%0b ir=%0b expected acc=0 ovf=0 ov=0 ir=1",
               bus.acc_out, bus.ovf, bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    send_vector(1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain ov=%0b ir=%0b expected ov=0 ir=0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== EXP_MAIN || bus.ovf !== 4'd0) begin
      failures++;
      $display("FAIL basic_result ov=%0b acc=%0h ovf=%0b expected ov=1 acc=%0h ovf=0",
               bus.out_valid, bus.acc_out, bus.ovf, EXP_MAIN);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.acc_out !== 96'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_consume acc=%0h ir=%0b ov=%0b expected acc=0 ir=1 ov=0",
               bus.acc_out, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_backpressure;
    send_vector(1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    set_beat(9);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.acc_out !== EXP_MAIN || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d acc=%0h ov=%0b ir=%0b expected acc=%0h ov=1 ir=0",
                 c, bus.acc_out, bus.out_valid, bus.in_ready, EXP_MAIN);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.acc_out !== 96'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release acc=%0h ir=%0b expected acc=0 ir=1", bus.acc_out, bus.in_ready);
    end
  endtask

  task automatic test_gapped;
    send_vector(1'b1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL gap_drain ov=%0b ir=%0b expected ov=0 ir=0", bus.out_valid, bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== EXP_MAIN || bus.ovf !== 4'd0) begin
      failures++;
      $display("FAIL gap_result ov=%0b acc=%0h ovf=%0b expected ov=1 acc=%0h ovf=0",
               bus.out_valid, bus.acc_out, bus.ovf, EXP_MAIN);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clr;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_beat(k);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (bus.acc_out !== 96'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_state acc=%0h ir=%0b expected acc=0 ir=1", bus.acc_out, bus.in_ready);
    end
    bus.a_in = {4{8'd1}};
    bus.b_in = {4{8'd1}};
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.acc_out !== EXP_ONES) begin
      failures++;
      $display("FAIL clr_next_vector ov=%0b acc=%0h expected ov=1 acc=%0h",
               bus.out_valid, bus.acc_out, EXP_ONES);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    bus2.a_in = {8'd1, 8'd255};
    bus2.b_in = {8'd1, 8'd255};
    @(negedge clk);
    bus2.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    bus2.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus2.out_valid !== 1'b1 || bus2.acc_out !== EXP_OVF || bus2.ovf !== 2'b01) begin
      failures++;
      $display("FAIL overflow ov=%0b acc=%0h ovf=%0b expected ov=1 acc=%0h ovf=01",
               bus2.out_valid, bus2.acc_out, bus2.ovf, EXP_OVF);
    end
    bus2.out_ready = 1'b1;
    @(negedge clk);
    bus2.out_ready = 1'b0;
    checks++;
    if (bus2.acc_out !== 32'd0 || bus2.ovf !== 2'b00 || bus2.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL overflow_consume acc=%0h ovf=%0b ir=%0b expected acc=0 ovf=0 ir=1",
               bus2.acc_out, bus2.ovf, bus2.in_ready);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    bus2.a_in = '0;
    bus2.b_in = '0;
    test_reset;
    test_basic;
    test_backpressure;
    test_gapped;
    test_clr;
    test_overflow;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
